// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART byte path
package uart_pkg;

   localparam int unsigned UART_DATA_BITS            = 8;
   localparam int unsigned UART_CLKS_PER_BIT_DEFAULT = 868;

   typedef enum logic [2:0] {
      IDLE,
      POP,
      WAIT,
      LOAD,
      START,
      DATA,
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with synchronous restart
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   output logic bit_tick_o,
   output logic pre_tick_o
);

   localparam int unsigned W = $clog2(CLKS_PER_BIT);
   localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
   localparam logic [W-1:0] PRE  = W'(CLKS_PER_BIT - 2);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clear_i || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // pre_tick lets the parent register an output that lands on the last cycle of a bit
   assign bit_tick_o = (cnt_q == LAST);
   assign pre_tick_o = (cnt_q == PRE);

endmodule

// File: rtl/uart_fifo_drain_tx.sv
// rtl/uart_fifo_drain_tx.sv - drains the byte FIFO and serialises each byte as 8N1
module uart_fifo_drain_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                      clock_100M,
   input  logic                      reset_n,
   input  logic                      enable,
   input  logic                      fifo_empty,
   input  logic [UART_DATA_BITS-1:0] fifo_data,
   output logic                      tx_irq,
   output logic                      uart_txd,
   output logic                      tx_busy,
   output logic                      tx_done,
   output logic [7:0]                byte_count
);

   uart_state_e               state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]                bit_cnt_q, bit_cnt_d;
   logic                      stop_cnt_q, stop_cnt_d;
   logic                      txd_q, txd_d;
   logic                      irq_q, irq_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic [7:0]                count_q, count_d;
   logic                      baud_clear, bit_tick, pre_tick, last_stop;

   assign baud_clear = !(state_q inside {START, DATA, STOP});
   assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_cnt_q;

   uart_baud_tick #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i     (clock_100M),
      .rst_ni    (reset_n),
      .clear_i   (baud_clear),
      .bit_tick_o(bit_tick),
      .pre_tick_o(pre_tick)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      done_d     = 1'b0;
      count_d    = count_q;

      case (state_q)
         IDLE:  if (enable && !fifo_empty) state_d = POP;
         POP:   state_d = WAIT;
         WAIT:  state_d = LOAD;
         LOAD: begin
            shift_d = fifo_data;
            state_d = START;
         end
         START: begin
            if (bit_tick) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == 3'd7) begin
                  state_d    = STOP;
                  bit_cnt_d  = 3'd0;
                  stop_cnt_d = 1'b0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         STOP: begin
            if (pre_tick && last_stop) begin
               done_d  = 1'b1;
               count_d = count_q + 8'd1;
            end
            if (bit_tick) begin
               if (last_stop) state_d = IDLE;
               else           stop_cnt_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so the registered pins line up with it
      irq_d  = (state_d == POP);
      busy_d = (state_d != IDLE);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clock_100M or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= 3'd0;
         stop_cnt_q <= 1'b0;
         txd_q      <= 1'b1;
         irq_q      <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         txd_q      <= txd_d;
         irq_q      <= irq_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         count_q    <= count_d;
      end
   end

   assign tx_irq     = irq_q;
   assign uart_txd   = txd_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign byte_count = count_q;

endmodule

// File: tb/tb_uart_fifo_drain_tx.sv
// tb/tb_uart_fifo_drain_tx.sv - self-checking bench for uart_fifo_drain_tx
module tb_uart_fifo_drain_tx;

   localparam int C  = 4;
   localparam int L1 = 3 + 10 * C;

   logic       clk = 1'b0;
   logic       reset_n, enable;
   logic       fifo_empty = 1'b1;
   logic [7:0] fifo_data  = 8'h00;
   logic       tx_irq, uart_txd, tx_busy, tx_done;
   logic [7:0] byte_count;
   logic       fifo_empty2;
   logic [7:0] fifo_data2;
   logic       tx_irq2, uart_txd2, tx_busy2, tx_done2;
   logic [7:0] byte_count2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   uart_fifo_drain_tx #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut (
      .clock_100M(clk), .reset_n(reset_n), .enable(enable),
      .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .tx_irq(tx_irq), .uart_txd(uart_txd), .tx_busy(tx_busy),
      .tx_done(tx_done), .byte_count(byte_count)
   );

   uart_fifo_drain_tx #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut2 (
      .clock_100M(clk), .reset_n(reset_n), .enable(enable),
      .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
      .tx_irq(tx_irq2), .uart_txd(uart_txd2), .tx_busy(tx_busy2),
      .tx_done(tx_done2), .byte_count(byte_count2)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // FIFO with one-cycle read latency and an Empty_Flag that lags one cycle
   logic [7:0] fq[$];
   logic [7:0] exp_q[$];
   always @(posedge clk) begin
      fifo_empty <= (fq.size() == 0);
      if (tx_irq && fq.size() != 0) fifo_data <= fq.pop_front();
   end

   // Frame model: k counts cycles since the pop (-1 = idle)
   int         k      = -1;
   int         mcount = 0;
   logic [7:0] mbyte  = 8'h00;
   always @(posedge clk) begin
      if (!reset_n) begin
         k      = -1;
         mcount = 0;
      end else if (k < 0) begin
         if (enable && !fifo_empty) begin
            chk("model_queue", 32'(exp_q.size() != 0), 1);
            mbyte = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            k     = 0;
         end
      end else if (k == L1 - 1) begin
         k = -1;
      end else begin
         k++;
         if (k == L1 - 1) mcount = (mcount + 1) % 256;
      end
   end

   function automatic logic exp_txd();
      int j;
      if (k < 3) return 1'b1;
      j = (k - 3) / C;
      if (j == 0) return 1'b0;
      if (j <= 8) return mbyte[j-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         chk("m_txd",   32'(uart_txd),   32'(exp_txd()));
         chk("m_irq",   32'(tx_irq),     32'(k == 0));
         chk("m_busy",  32'(tx_busy),    32'(k >= 0));
         chk("m_done",  32'(tx_done),    32'(k == L1 - 1));
         chk("m_count", 32'(byte_count), mcount);
      end
   end

   logic       s_txd[$];
   logic       s_irq[$];
   int         n_irq, n_busy, n_done;
   logic [7:0] dec_bytes[$];
   int         dec_start[$];

   task automatic clear_samples();
      s_txd.delete();
      s_irq.delete();
      n_irq  = 0;
      n_busy = 0;
      n_done = 0;
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         s_txd.push_back(uart_txd);
         s_irq.push_back(tx_irq);
         if (tx_irq)  n_irq++;
         if (tx_busy) n_busy++;
         if (tx_done) n_done++;
      end
   endtask

   task automatic push(input logic [7:0] b);
      fq.push_back(b);
      exp_q.push_back(b);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      run_cycles(2);
      reset_n = 1'b1;
   endtask

   task automatic wait_pop(output int p);
      p = -1;
      for (int i = 0; i < 60 && p < 0; i++) begin
         run_cycles(1);
         if (s_irq[s_irq.size()-1]) p = s_irq.size() - 1;
      end
      chk("pop_seen", 32'(p >= 0), 1);
   endtask

   // Recover bytes from the sampled line by mid-bit sampling after each falling edge
   function automatic void decode();
      int i;
      logic [7:0] b;
      dec_bytes.delete();
      dec_start.delete();
      i = 1;
      while (i + 10 * C <= s_txd.size()) begin
         if (s_txd[i-1] && !s_txd[i]) begin
            for (int j = 0; j < 8; j++) b[j] = s_txd[i + C * (j + 1) + C / 2];
            dec_bytes.push_back(b);
            dec_start.push_back(i);
            i += 10 * C;
         end else begin
            i++;
         end
      end
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int         p, f, m, found, busy2, done_k, done_n, stop_hi, start_lo;
      logic [9:0] lv;
      logic [7:0] d2;
      reset_n     = 1'b0;
      enable      = 1'b1;
      fifo_empty2 = 1'b1;
      fifo_data2  = 8'h81;
      clear_samples();
      run_cycles(3);
      chk("rst_txd",   32'(uart_txd),   1);
      chk("rst_irq",   32'(tx_irq),     0);
      chk("rst_busy",  32'(tx_busy),    0);
      chk("rst_done",  32'(tx_done),    0);
      chk("rst_count", 32'(byte_count), 0);
      reset_n = 1'b1;
      clear_samples();
      run_cycles(100);
      chk("idle_no_irq", n_irq, 0);

      // single byte 0x55
      clear_samples();
      push(8'h55);
      run_cycles(60);
      decode();
      chk("b55_irq",    n_irq, 1);
      chk("b55_frames", dec_bytes.size(), 1);
      if (dec_bytes.size() > 0) begin
         chk("b55_byte", 32'(dec_bytes[0]), 32'h55);
         f  = dec_start[0];
         lv = 10'b1010101010;
         for (int j = 0; j < 10; j++) begin
            m = 0;
            for (int c = 0; c < C; c++) if (s_txd[f + C * j + c] == lv[j]) m++;
            chk($sformatf("b55_level%0d", j), m, C);
         end
      end
      chk("b55_busy",  n_busy, 43);
      chk("b55_done",  n_done, 1);
      chk("b55_count", 32'(byte_count), 1);
      chk("model_count_pin", mcount, 1);

      // three queued bytes back to back
      do_reset();
      clear_samples();
      push(8'hA3);
      push(8'h00);
      push(8'hFF);
      run_cycles(152);
      decode();
      chk("b3_irq",    n_irq, 3);
      chk("b3_done",   n_done, 3);
      chk("b3_frames", dec_bytes.size(), 3);
      if (dec_bytes.size() == 3) begin
         chk("b3_byte0", 32'(dec_bytes[0]), 32'hA3);
         chk("b3_byte1", 32'(dec_bytes[1]), 32'h00);
         chk("b3_byte2", 32'(dec_bytes[2]), 32'hFF);
         chk("b3_gap01", dec_start[1] - dec_start[0] - 10 * C, 4);
         chk("b3_gap12", dec_start[2] - dec_start[1] - 10 * C, 4);
      end
      chk("b3_count", 32'(byte_count), 3);

      // enable dropped mid-frame
      do_reset();
      clear_samples();
      push(8'h3C);
      push(8'h99);
      wait_pop(p);
      run_cycles(10);
      enable = 1'b0;
      run_cycles(100);
      decode();
      chk("en_frames", dec_bytes.size(), 1);
      if (dec_bytes.size() > 0) chk("en_byte0", 32'(dec_bytes[0]), 32'h3C);
      chk("en_irq_held", n_irq, 1);
      chk("en_count",    32'(byte_count), 1);
      enable = 1'b1;
      run_cycles(1);
      chk("en_resume", 32'(s_irq[s_irq.size()-1]), 1);
      run_cycles(60);
      decode();
      chk("en_frames2", dec_bytes.size(), 2);
      if (dec_bytes.size() > 1) chk("en_byte1", 32'(dec_bytes[1]), 32'h99);
      chk("en_count2", 32'(byte_count), 2);

      // reset in the middle of data bit 3
      do_reset();
      clear_samples();
      push(8'hC5);
      push(8'h5A);
      wait_pop(p);
      run_cycles(21);
      chk("rmid_pre_txd", 32'(s_txd[s_txd.size()-1]), 0);
      reset_n = 1'b0;
      #1;
      chk("rmid_txd_async",  32'(uart_txd), 1);
      chk("rmid_busy_async", 32'(tx_busy),  0);
      run_cycles(2);
      reset_n = 1'b1;
      clear_samples();
      run_cycles(60);
      decode();
      chk("rmid_frames", dec_bytes.size(), 1);
      if (dec_bytes.size() > 0) chk("rmid_byte", 32'(dec_bytes[0]), 32'h5A);
      chk("rmid_irq",   n_irq, 1);
      chk("rmid_count", 32'(byte_count), 1);

      // two stop bits, byte 0x81
      fifo_empty2 = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         @(negedge clk);
         #1;
         if (tx_irq2) found = 1;
      end
      fifo_empty2 = 1'b1;
      chk("sb2_pop_seen", found, 1);
      busy2 = tx_busy2 ? 1 : 0;
      done_k = -1; done_n = 0; stop_hi = 0; start_lo = 0; d2 = 8'h00;
      for (int kk = 1; kk < 56; kk++) begin
         @(negedge clk);
         #1;
         if (tx_busy2) busy2++;
         if (tx_done2) begin
            done_k = kk;
            done_n++;
         end
         if (kk == 5 && !uart_txd2) start_lo = 1;
         if (kk >= 9 && kk <= 37 && (kk - 9) % C == 0) d2[(kk - 9) / C] = uart_txd2;
         if (kk >= 39 && kk <= 46 && uart_txd2) stop_hi++;
      end
      chk("sb2_start",   start_lo, 1);
      chk("sb2_byte",    32'(d2), 32'h81);
      chk("sb2_stop_hi", stop_hi, 8);
      chk("sb2_done_at", done_k, 46);
      chk("sb2_done_n",  done_n, 1);
      chk("sb2_busy",    busy2, 47);
      chk("sb2_count",   32'(byte_count2), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
